// File: rtl/mpu_pkg.sv
// Shared constants for the MPU cluster control front-end: CSR offsets,
// STATUS/MASK field layout and the captured user-data width.
package mpu_pkg;

    localparam logic [3:0] OFF_CTRL     = 4'h0;
    localparam logic [3:0] OFF_RESET    = 4'h1;
    localparam logic [3:0] OFF_STATUS   = 4'h2;
    localparam logic [3:0] OFF_MASK     = 4'h3;
    localparam logic [3:0] OFF_SEL      = 4'h4;
    localparam logic [3:0] OFF_UDATA_LO = 4'h5;
    localparam logic [3:0] OFF_UDATA_HI = 4'h6;

    localparam int STAT_IRQ_BASE = 0;
    localparam int STAT_ERR_BASE = 16;

    localparam int UDATA_W = 64;

    // Implemented bits of STATUS/MASK for a given channel count.
    function automatic logic [31:0] stat_bits(input int n_ch);
        logic [31:0] ch_bits;
        ch_bits = (32'd1 << n_ch) - 32'd1;
        return (ch_bits << STAT_IRQ_BASE) | (ch_bits << STAT_ERR_BASE);
    endfunction

endpackage

// File: rtl/mpu_ch_ctl.sv
// Per-channel MPU control: run bit, timed reset pulse, input edge detects,
// pending bits and user-data capture register.
module mpu_ch_ctl
    import mpu_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               ctrl_we,
    input  logic               ctrl_wdata,
    input  logic               rst_start,
    input  logic               clr_irq,
    input  logic               clr_err,
    input  logic               user_irq,
    input  logic               error,
    input  logic [UDATA_W-1:0] user_data,
    output logic               run,
    output logic               mpu_rst,
    output logic               mpu_en,
    output logic               irq_pend,
    output logic               err_pend,
    output logic [UDATA_W-1:0] cap_data
);

    localparam int             PW        = $clog2(2 * CLK_DIV + 1);
    localparam logic [PW-1:0]  PULSE_LEN = PW'(2 * CLK_DIV);

    logic [PW-1:0] rst_cnt;
    logic          irq_hist;
    logic          err_hist;
    logic          irq_rise;
    logic          err_rise;

    assign irq_rise = user_irq & ~irq_hist;
    assign err_rise = error & ~err_hist;
    assign mpu_rst  = (rst_cnt != '0);

    // Set events take priority over software clears and CTRL writes.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            run      <= 1'b0;
            rst_cnt  <= PULSE_LEN;
            irq_hist <= 1'b0;
            err_hist <= 1'b0;
            irq_pend <= 1'b0;
            err_pend <= 1'b0;
            cap_data <= '0;
            mpu_en   <= 1'b0;
        end else begin
            irq_hist <= user_irq;
            err_hist <= error;

            if (err_rise) begin
                run <= 1'b0;
            end else if (ctrl_we) begin
                run <= ctrl_wdata;
            end

            if (rst_start) begin
                rst_cnt <= PULSE_LEN;
            end else if (rst_cnt != '0) begin
                rst_cnt <= rst_cnt - 1'b1;
            end

            if (irq_rise) begin
                irq_pend <= 1'b1;
            end else if (clr_irq) begin
                irq_pend <= 1'b0;
            end

            if (err_rise) begin
                err_pend <= 1'b1;
            end else if (clr_err) begin
                err_pend <= 1'b0;
            end

            if (irq_rise) begin
                cap_data <= user_data;
            end

            mpu_en <= run & ~mpu_rst;
        end
    end

endmodule

// File: rtl/mpu_ctl_multi.sv
// CSR decode, MPU clock-enable strobe, read mux and interrupt aggregation
// for a cluster of N_CH MPU channels sharing one CSR slot.
module mpu_ctl_multi
    import mpu_pkg::*;
#(
    parameter logic [3:0] csr_addr = 4'h0,
    parameter int         N_CH     = 4,
    parameter int         CLK_DIV  = 2
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic [13:0]               csr_a,
    input  logic                      csr_we,
    input  logic [31:0]               csr_di,
    output logic [31:0]               csr_do,
    output logic                      mpu_ce,
    output logic [N_CH-1:0]           mpu_en,
    output logic [N_CH-1:0]           mpu_rst,
    input  logic [N_CH-1:0]           user_irq,
    input  logic [UDATA_W*N_CH-1:0]   user_data,
    input  logic [N_CH-1:0]           error,
    output logic                      irq
);

    localparam int               CE_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CE_W-1:0]  CE_LAST   = CE_W'(CLK_DIV - 1);
    localparam logic [31:0]      STAT_BITS = stat_bits(N_CH);

    logic                csr_sel;
    logic [3:0]          csr_off;
    logic                csr_wr;
    logic                wr_ctrl;
    logic                wr_reset;
    logic                wr_status;
    logic                wr_mask;
    logic                wr_sel;
    logic                csr_unused;
    logic [CE_W-1:0]     ce_cnt;
    logic [CE_W-1:0]     ce_cnt_nxt;
    logic [31:0]         mask_q;
    logic [31:0]         status_v;
    logic [31:0]         rdata;
    logic [2:0]          sel_q;
    logic [N_CH-1:0]     run;
    logic [N_CH-1:0]     irq_pend;
    logic [N_CH-1:0]     err_pend;
    logic [UDATA_W-1:0]  cap_data [N_CH];
    logic [UDATA_W-1:0]  udata;

    assign csr_sel    = (csr_a[13:10] == csr_addr);
    assign csr_off    = csr_a[3:0];
    assign csr_wr     = csr_sel & csr_we;
    assign wr_ctrl    = csr_wr & (csr_off == OFF_CTRL);
    assign wr_reset   = csr_wr & (csr_off == OFF_RESET);
    assign wr_status  = csr_wr & (csr_off == OFF_STATUS);
    assign wr_mask    = csr_wr & (csr_off == OFF_MASK);
    assign wr_sel     = csr_wr & (csr_off == OFF_SEL);
    assign csr_unused = ^csr_a[9:4];

    for (genvar n = 0; n < N_CH; n++) begin : g_ch
        mpu_ch_ctl #(
            .CLK_DIV (CLK_DIV)
        ) u_ch (
            .sys_clk    (sys_clk),
            .sys_rst    (sys_rst),
            .ctrl_we    (wr_ctrl),
            .ctrl_wdata (csr_di[n]),
            .rst_start  (wr_reset & csr_di[n]),
            .clr_irq    (wr_status & csr_di[STAT_IRQ_BASE + n]),
            .clr_err    (wr_status & csr_di[STAT_ERR_BASE + n]),
            .user_irq   (user_irq[n]),
            .error      (error[n]),
            .user_data  (user_data[UDATA_W*n +: UDATA_W]),
            .run        (run[n]),
            .mpu_rst    (mpu_rst[n]),
            .mpu_en     (mpu_en[n]),
            .irq_pend   (irq_pend[n]),
            .err_pend   (err_pend[n]),
            .cap_data   (cap_data[n])
        );
    end

    assign ce_cnt_nxt = (ce_cnt == CE_LAST) ? '0 : ce_cnt + 1'b1;

    always_comb begin
        status_v = '0;
        status_v[STAT_IRQ_BASE +: N_CH] = irq_pend;
        status_v[STAT_ERR_BASE +: N_CH] = err_pend;
    end

    // Out-of-range SEL matches no channel and reads as zero.
    always_comb begin
        udata = '0;
        for (int n = 0; n < N_CH; n++) begin
            if (sel_q == 3'(n)) begin
                udata = cap_data[n];
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (csr_off)
            OFF_CTRL:     rdata[N_CH-1:0] = run;
            OFF_RESET:    rdata[N_CH-1:0] = mpu_rst;
            OFF_STATUS:   rdata = status_v;
            OFF_MASK:     rdata = mask_q;
            OFF_SEL:      rdata[2:0] = sel_q;
            OFF_UDATA_LO: rdata = udata[31:0];
            OFF_UDATA_HI: rdata = udata[63:32];
            default:      rdata = '0;
        endcase
    end

    // mpu_ce is registered so that it is held low during reset even when CLK_DIV=1.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            ce_cnt <= '0;
            mpu_ce <= 1'b0;
            mask_q <= '0;
            sel_q  <= '0;
            csr_do <= '0;
            irq    <= 1'b0;
        end else begin
            ce_cnt <= ce_cnt_nxt;
            mpu_ce <= (ce_cnt_nxt == CE_LAST);
            if (wr_mask) begin
                mask_q <= csr_di & STAT_BITS;
            end
            if (wr_sel) begin
                sel_q <= csr_di[2:0];
            end
            csr_do <= csr_sel ? rdata : '0;
            irq    <= |(status_v & mask_q);
        end
    end

endmodule

// File: tb/tb_mpu_ctl_multi.sv
// Bench for mpu_ctl_multi: directed scenarios plus a randomized run checked
// against a cycle-level reference model of the register behaviour.
module tb_mpu_ctl_multi;

    localparam int          N_CH     = 4;
    localparam int          CLK_DIV  = 2;
    localparam logic [3:0]  CSR_SLOT = 4'h0;
    localparam logic [31:0] STAT_BITS = 32'h000F_000F;

    localparam logic [3:0] R_CTRL   = 4'h0;
    localparam logic [3:0] R_RESET  = 4'h1;
    localparam logic [3:0] R_STATUS = 4'h2;
    localparam logic [3:0] R_MASK   = 4'h3;
    localparam logic [3:0] R_SEL    = 4'h4;
    localparam logic [3:0] R_UD_LO  = 4'h5;
    localparam logic [3:0] R_UD_HI  = 4'h6;

    logic                  sys_clk = 1'b0;
    logic                  sys_rst = 1'b0;
    logic [13:0]           csr_a = '0;
    logic                  csr_we = 1'b0;
    logic [31:0]           csr_di = '0;
    logic [31:0]           csr_do;
    logic                  mpu_ce;
    logic [N_CH-1:0]       mpu_en;
    logic [N_CH-1:0]       mpu_rst;
    logic [N_CH-1:0]       user_irq = '0;
    logic [64*N_CH-1:0]    user_data = '0;
    logic [N_CH-1:0]       error = '0;
    logic                  irq;

    int tests = 0;
    int fails = 0;

    mpu_ctl_multi #(
        .csr_addr (CSR_SLOT),
        .N_CH     (N_CH),
        .CLK_DIV  (CLK_DIV)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .csr_a     (csr_a),
        .csr_we    (csr_we),
        .csr_di    (csr_di),
        .csr_do    (csr_do),
        .mpu_ce    (mpu_ce),
        .mpu_en    (mpu_en),
        .mpu_rst   (mpu_rst),
        .user_irq  (user_irq),
        .user_data (user_data),
        .error     (error),
        .irq       (irq)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model: cycle index since reset release, and for each channel
    // the cycle index at which its reset pulse ends.
    int          m_cyc;
    int          m_rst_end [N_CH];
    logic [3:0]  m_ctrl, m_irqp, m_errp, m_hist_irq, m_hist_err, m_en;
    logic [31:0] m_mask, m_do;
    logic [2:0]  m_sel;
    logic [63:0] m_cap [N_CH];
    logic        m_ce, m_irq;

    task automatic m_reset();
        m_cyc = 0;
        for (int n = 0; n < N_CH; n++) begin
            m_rst_end[n] = 2 * CLK_DIV;
            m_cap[n] = '0;
        end
        m_ctrl = '0; m_irqp = '0; m_errp = '0; m_hist_irq = '0; m_hist_err = '0;
        m_en = '0; m_mask = '0; m_do = '0; m_sel = '0; m_ce = 1'b0; m_irq = 1'b0;
    endtask

    function automatic logic [3:0] m_rst_vec();
        logic [3:0] v;
        for (int n = 0; n < N_CH; n++) v[n] = (m_cyc < m_rst_end[n]);
        return v;
    endfunction

    function automatic logic [31:0] m_status();
        return {12'h0, m_errp, 12'h0, m_irqp};
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] off);
        int idx;
        idx = int'(m_sel);
        case (off)
            R_CTRL:   return {28'h0, m_ctrl};
            R_RESET:  return {28'h0, m_rst_vec()};
            R_STATUS: return m_status();
            R_MASK:   return m_mask;
            R_SEL:    return {29'h0, m_sel};
            R_UD_LO:  return (idx < N_CH) ? m_cap[idx][31:0] : 32'h0;
            R_UD_HI:  return (idx < N_CH) ? m_cap[idx][63:32] : 32'h0;
            default:  return 32'h0;
        endcase
    endfunction

    task automatic m_step();
        logic [3:0] rst_now, ir, er, clr_i, clr_e;
        logic       hit, wr;
        logic [3:0] off;
        rst_now = m_rst_vec();
        ir  = user_irq & ~m_hist_irq;
        er  = error & ~m_hist_err;
        hit = (csr_a[13:10] == CSR_SLOT);
        off = csr_a[3:0];
        wr  = hit & csr_we;
        m_do  = hit ? m_read(off) : 32'h0;
        m_irq = |(m_status() & m_mask);
        m_en  = m_ctrl & ~rst_now;
        m_ce  = ((m_cyc + 1) % CLK_DIV) == (CLK_DIV - 1);
        if (wr && off == R_CTRL) m_ctrl = csr_di[3:0];
        m_ctrl = m_ctrl & ~er;
        if (wr && off == R_RESET)
            for (int n = 0; n < N_CH; n++)
                if (csr_di[n]) m_rst_end[n] = m_cyc + 1 + 2 * CLK_DIV;
        clr_i = (wr && off == R_STATUS) ? csr_di[3:0] : 4'h0;
        clr_e = (wr && off == R_STATUS) ? csr_di[19:16] : 4'h0;
        m_irqp = (m_irqp & ~clr_i) | ir;
        m_errp = (m_errp & ~clr_e) | er;
        if (wr && off == R_MASK) m_mask = csr_di & STAT_BITS;
        if (wr && off == R_SEL) m_sel = csr_di[2:0];
        for (int n = 0; n < N_CH; n++)
            if (ir[n]) m_cap[n] = user_data[64*n +: 64];
        m_hist_irq = user_irq;
        m_hist_err = error;
        m_cyc++;
    endtask

    task automatic cycle();
        m_step();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic [13:0] addr(input logic [3:0] off);
        return {CSR_SLOT, 6'h0, off};
    endfunction

    task automatic csr_wr(input logic [3:0] off, input logic [31:0] data);
        csr_a = addr(off); csr_we = 1'b1; csr_di = data;
        cycle();
        csr_we = 1'b0;
    endtask

    task automatic csr_rd(input logic [3:0] off, output logic [31:0] data);
        csr_a = addr(off); csr_we = 1'b0;
        cycle();
        data = csr_do;
    endtask

    task automatic test_reset();
        logic ce_exp;
        sys_rst = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        tests++;
        if (mpu_rst !== 4'hF || mpu_en !== 4'h0 || mpu_ce !== 1'b0 || irq !== 1'b0 || csr_do !== 32'h0) begin
            $display("FAIL in_reset: rst=%h en=%h ce=%b irq=%b do=%h, expected F 0 0 0 0", mpu_rst, mpu_en, mpu_ce, irq, csr_do);
            fails++;
        end
        sys_rst = 1'b1;
        m_reset();
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (mpu_rst !== ((i < 2 * CLK_DIV) ? 4'hF : 4'h0)) begin
                $display("FAIL release_rst cycle %0d: got %h expected %h", i, mpu_rst, (i < 2 * CLK_DIV) ? 4'hF : 4'h0);
                fails++;
            end
            ce_exp = (i >= 1) && ((i % CLK_DIV) == CLK_DIV - 1);
            tests++;
            if (mpu_ce !== ce_exp) begin
                $display("FAIL release_ce cycle %0d: got %b expected %b", i, mpu_ce, ce_exp);
                fails++;
            end
            tests++;
            if (mpu_en !== 4'h0 || irq !== 1'b0 || csr_do !== 32'h0) begin
                $display("FAIL release_quiet cycle %0d: en=%h irq=%b do=%h expected all 0", i, mpu_en, irq, csr_do);
                fails++;
            end
            cycle();
        end
    endtask

    task automatic test_run_halt();
        logic [31:0] d;
        csr_wr(R_CTRL, 32'h5);
        cycle();
        tests++;
        if (mpu_en !== 4'b0101) begin
            $display("FAIL run_en: got %b expected 0101", mpu_en); fails++;
        end
        error[2] = 1'b1;
        cycle();
        cycle();
        csr_rd(R_CTRL, d);
        tests++;
        if (d !== 32'h1) begin
            $display("FAIL halt_ctrl: got %h expected 00000001", d); fails++;
        end
        csr_rd(R_STATUS, d);
        tests++;
        if (d !== 32'h0004_0000) begin
            $display("FAIL halt_status: got %h expected 00040000", d); fails++;
        end
        tests++;
        if (mpu_en !== 4'b0001) begin
            $display("FAIL halt_en: got %b expected 0001", mpu_en); fails++;
        end
        error = '0;
        csr_wr(R_STATUS, 32'h0004_0000);
        csr_rd(R_STATUS, d);
        tests++;
        if (d !== 32'h0) begin
            $display("FAIL err_w1c: got %h expected 00000000", d); fails++;
        end
    endtask

    task automatic test_irq_capture();
        logic [31:0] d;
        csr_wr(R_MASK, 32'h2);
        user_data[64 +: 64] = 64'hDEAD_BEEF_0123_4567;
        user_irq[1] = 1'b1;
        cycle();
        tests++;
        if (irq !== 1'b0) begin
            $display("FAIL irq_early: got %b expected 0", irq); fails++;
        end
        user_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        cycle();
        tests++;
        if (irq !== 1'b1) begin
            $display("FAIL irq_rise: got %b expected 1", irq); fails++;
        end
        csr_wr(R_SEL, 32'h1);
        csr_rd(R_UD_LO, d);
        tests++;
        if (d !== 32'h0123_4567) begin
            $display("FAIL udata_lo: got %h expected 01234567", d); fails++;
        end
        csr_rd(R_UD_HI, d);
        tests++;
        if (d !== 32'hDEAD_BEEF) begin
            $display("FAIL udata_hi: got %h expected deadbeef", d); fails++;
        end
        csr_wr(R_STATUS, 32'h2);
        cycle();
        tests++;
        if (irq !== 1'b0) begin
            $display("FAIL irq_w1c: got %b expected 0", irq); fails++;
        end
    endtask

    task automatic test_set_clear();
        logic [31:0] d;
        user_irq[0] = 1'b1;
        error[0] = 1'b1;
        csr_wr(R_STATUS, 32'h0001_0001);
        csr_rd(R_STATUS, d);
        tests++;
        if (d !== 32'h0001_0001) begin
            $display("FAIL set_beats_clear: got %h expected 00010001", d); fails++;
        end
        csr_wr(R_STATUS, 32'h0001_0001);
        csr_rd(R_STATUS, d);
        tests++;
        if (d !== 32'h0) begin
            $display("FAIL plain_clear: got %h expected 00000000", d); fails++;
        end
        user_irq = '0;
        error = '0;
    endtask

    task automatic test_reset_restart();
        int   hi;
        logic others;
        csr_wr(R_CTRL, 32'h9);
        cycle();
        csr_wr(R_RESET, 32'h8);
        hi = 0;
        others = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (mpu_rst[3]) hi++;
            if (mpu_rst[2:0] !== 3'b000) others = 1'b1;
            if (i == 1) csr_wr(R_RESET, 32'h8);
            else cycle();
        end
        tests++;
        if (hi != 2 + 2 * CLK_DIV) begin
            $display("FAIL restart_len: got %0d cycles expected %0d", hi, 2 + 2 * CLK_DIV); fails++;
        end
        tests++;
        if (others !== 1'b0) begin
            $display("FAIL restart_other_ch: got %b expected 0", others); fails++;
        end
        tests++;
        if (mpu_en !== 4'b1001) begin
            $display("FAIL restart_en: got %b expected 1001", mpu_en); fails++;
        end
    endtask

    task automatic test_decode_bounds();
        logic [31:0] d;
        csr_a = {4'h5, 6'h0, R_CTRL}; csr_we = 1'b1; csr_di = 32'h0;
        cycle();
        csr_we = 1'b0;
        tests++;
        if (csr_do !== 32'h0) begin
            $display("FAIL unsel_read: got %h expected 00000000", csr_do); fails++;
        end
        csr_rd(R_CTRL, d);
        tests++;
        if (d !== 32'h9) begin
            $display("FAIL unsel_write: got %h expected 00000009", d); fails++;
        end
        csr_wr(4'h7, 32'hFFFF_FFFF);
        csr_rd(4'h7, d);
        tests++;
        if (d !== 32'h0) begin
            $display("FAIL undef_offset: got %h expected 00000000", d); fails++;
        end
        csr_wr(R_SEL, 32'h7);
        csr_rd(R_SEL, d);
        tests++;
        if (d !== 32'h7) begin
            $display("FAIL sel_readback: got %h expected 00000007", d); fails++;
        end
        csr_rd(R_UD_LO, d);
        tests++;
        if (d !== 32'h0) begin
            $display("FAIL sel_oob_lo: got %h expected 00000000", d); fails++;
        end
        csr_rd(R_UD_HI, d);
        tests++;
        if (d !== 32'h0) begin
            $display("FAIL sel_oob_hi: got %h expected 00000000", d); fails++;
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        csr_wr(R_RESET, 32'h2);
        cycle();
        #2;
        sys_rst = 1'b0;
        #1;
        tests++;
        if (mpu_rst !== 4'hF || mpu_en !== 4'h0 || mpu_ce !== 1'b0 || irq !== 1'b0 || csr_do !== 32'h0) begin
            $display("FAIL async_abort: rst=%h en=%h ce=%b irq=%b do=%h, expected F 0 0 0 0", mpu_rst, mpu_en, mpu_ce, irq, csr_do);
            fails++;
        end
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b1;
        m_reset();
        csr_rd(R_CTRL, d);
        tests++;
        if (d !== 32'h0) begin
            $display("FAIL async_ctrl: got %h expected 00000000", d); fails++;
        end
        csr_rd(R_SEL, d);
        tests++;
        if (d !== 32'h0) begin
            $display("FAIL async_sel: got %h expected 00000000", d); fails++;
        end
    endtask

    task automatic test_random();
        logic [3:0] off;
        for (int i = 0; i < 600; i++) begin
            user_irq = user_irq ^ (4'($urandom) & 4'($urandom));
            error    = error ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
            user_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            off = 4'($urandom_range(0, 8));
            csr_a = {(($urandom_range(0, 3) == 0) ? 4'($urandom) : CSR_SLOT), 6'($urandom), off};
            csr_we = ($urandom_range(0, 2) == 0);
            csr_di = $urandom;
            cycle();
            tests++;
            if (mpu_rst !== m_rst_vec()) begin
                $display("FAIL rand_rst cycle %0d: got %h expected %h", i, mpu_rst, m_rst_vec()); fails++;
            end
            tests++;
            if (mpu_en !== m_en) begin
                $display("FAIL rand_en cycle %0d: got %h expected %h", i, mpu_en, m_en); fails++;
            end
            tests++;
            if (mpu_ce !== m_ce) begin
                $display("FAIL rand_ce cycle %0d: got %b expected %b", i, mpu_ce, m_ce); fails++;
            end
            tests++;
            if (irq !== m_irq) begin
                $display("FAIL rand_irq cycle %0d: got %b expected %b", i, irq, m_irq); fails++;
            end
            tests++;
            if (csr_do !== m_do) begin
                $display("FAIL rand_csr_do cycle %0d: got %h expected %h", i, csr_do, m_do); fails++;
            end
        end
        csr_we = 1'b0;
        user_irq = '0;
        error = '0;
    endtask

    initial begin
        m_reset();
        test_reset();
        test_run_halt();
        test_irq_capture();
        test_set_clear();
        test_reset_restart();
        test_decode_bounds();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
